// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs and pipeline-register write/bubble controls exchanged between
// the datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
);
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_use_rs1;
   logic                  id_use_rs2;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_mem_read;
   logic                  ex_branch_taken;
   logic                  mem_active;
   logic                  mem_ready;
   logic                  pc_we;
   logic                  ifid_we;
   logic                  ifid_empty;
   logic                  idex_we;
   logic                  idex_empty;
   logic                  exmem_we;
   logic                  exmem_empty;
   logic                  memwb_we;
   logic                  memwb_empty;
   logic                  fault;
   logic [1:0]            hazard_state;
   logic [CNT_W-1:0]      stall_cycles;
   logic [CNT_W-1:0]      flush_count;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             ex_branch_taken, mem_active, mem_ready,
      input  pc_we, ifid_we, ifid_empty, idex_we, idex_empty, exmem_we,
             exmem_empty, memwb_we, memwb_empty, fault, hazard_state,
             stall_cycles, flush_count
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             ex_branch_taken, mem_active, mem_ready,
      output pc_we, ifid_we, ifid_empty, idex_we, idex_empty, exmem_we,
             exmem_empty, memwb_we, memwb_empty, fault, hazard_state,
             stall_cycles, flush_count
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch and memory wait
// with timeout-to-fault. Performance counters are built only when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W     = 5,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   pipeline_hazard_ctrl_if.slave hz
);
   localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FAULT    = 2'd2
   } state_t;

   state_t                state_r;
   state_t                state_nxt_s;
   logic [WCNT_W-1:0]     wait_cnt_r;
   logic [WCNT_W-1:0]     wait_cnt_nxt_s;
   logic [REG_ADDR_W-1:0] ex_rd_s;
   logic                  load_use_s;
   logic                  mem_stall_s;
   logic                  branch_act_s;
   logic                  pc_we_s, ifid_we_s, ifid_empty_s, idex_we_s, idex_empty_s;
   logic                  exmem_we_s, exmem_empty_s, memwb_we_s, memwb_empty_s;
   logic                  fault_s;

   assign ex_rd_s     = hz.ex_rd;
   assign load_use_s  = hz.ex_mem_read & (ex_rd_s != {REG_ADDR_W{1'b0}}) &
                        ((hz.id_use_rs1 & (hz.id_rs1 == ex_rd_s)) |
                         (hz.id_use_rs2 & (hz.id_rs2 == ex_rd_s)));
   assign mem_stall_s = hz.mem_active & ~hz.mem_ready;

   // State and wait counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_RUN;
         wait_cnt_r <= {WCNT_W{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
      end
   end

   // Next state and Mealy pipeline controls; reset forces every control low
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      pc_we_s        = 1'b1;
      ifid_we_s      = 1'b1;
      ifid_empty_s   = 1'b0;
      idex_we_s      = 1'b1;
      idex_empty_s   = 1'b0;
      exmem_we_s     = 1'b1;
      exmem_empty_s  = 1'b0;
      memwb_we_s     = 1'b1;
      memwb_empty_s  = 1'b0;
      fault_s        = 1'b0;
      branch_act_s   = 1'b0;
      if (rst) begin
         state_nxt_s    = ST_RUN;
         wait_cnt_nxt_s = {WCNT_W{1'b0}};
         pc_we_s        = 1'b0;
         ifid_we_s      = 1'b0;
         idex_we_s      = 1'b0;
         exmem_we_s     = 1'b0;
         memwb_we_s     = 1'b0;
      end else begin
         case (state_r)
            ST_RUN, ST_MEM_WAIT: begin
               if (mem_stall_s) begin
                  pc_we_s       = 1'b0;
                  ifid_we_s     = 1'b0;
                  idex_we_s     = 1'b0;
                  exmem_we_s    = 1'b0;
                  memwb_empty_s = 1'b1;
                  if (state_r == ST_RUN) begin
                     state_nxt_s    = ST_MEM_WAIT;
                     wait_cnt_nxt_s = {{(WCNT_W-1){1'b0}}, 1'b1};
                  end else if (wait_cnt_r == WCNT_W'(TIMEOUT_CYCLES)) begin
                     state_nxt_s = ST_FAULT;
                  end else begin
                     wait_cnt_nxt_s = wait_cnt_r + {{(WCNT_W-1){1'b0}}, 1'b1};
                  end
               end else begin
                  // Frozen EX/ID contents are re-evaluated here on release
                  state_nxt_s    = ST_RUN;
                  wait_cnt_nxt_s = {WCNT_W{1'b0}};
                  if (hz.ex_branch_taken) begin
                     ifid_empty_s = 1'b1;
                     idex_empty_s = 1'b1;
                     branch_act_s = 1'b1;
                  end else if (load_use_s) begin
                     pc_we_s      = 1'b0;
                     ifid_we_s    = 1'b0;
                     idex_empty_s = 1'b1;
                  end else begin
                     branch_act_s = 1'b0;
                  end
               end
            end
            ST_FAULT: begin
               pc_we_s    = 1'b0;
               ifid_we_s  = 1'b0;
               idex_we_s  = 1'b0;
               exmem_we_s = 1'b0;
               memwb_we_s = 1'b0;
               fault_s    = 1'b1;
            end
            default: begin
               state_nxt_s    = ST_RUN;
               wait_cnt_nxt_s = {WCNT_W{1'b0}};
               pc_we_s        = 1'b0;
               ifid_we_s      = 1'b0;
               idex_we_s      = 1'b0;
               exmem_we_s     = 1'b0;
               memwb_we_s     = 1'b0;
            end
         endcase
      end
   end

   assign hz.pc_we        = pc_we_s;
   assign hz.ifid_we      = ifid_we_s;
   assign hz.ifid_empty   = ifid_empty_s;
   assign hz.idex_we      = idex_we_s;
   assign hz.idex_empty   = idex_empty_s;
   assign hz.exmem_we     = exmem_we_s;
   assign hz.exmem_empty  = exmem_empty_s;
   assign hz.memwb_we     = memwb_we_s;
   assign hz.memwb_empty  = memwb_empty_s;
   assign hz.fault        = fault_s;
   assign hz.hazard_state = state_r;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cycles_r;
   logic [CNT_W-1:0] flush_count_r;

   // Saturating stall-cycle and flush counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_r <= {CNT_W{1'b0}};
         flush_count_r  <= {CNT_W{1'b0}};
      end else begin
         if ((state_r != ST_FAULT) && !pc_we_s && (stall_cycles_r != {CNT_W{1'b1}})) begin
            stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            stall_cycles_r <= stall_cycles_r;
         end
         if (branch_act_s && (flush_count_r != {CNT_W{1'b1}})) begin
            flush_count_r <= flush_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            flush_count_r <= flush_count_r;
         end
      end
   end

   assign hz.stall_cycles = stall_cycles_r;
   assign hz.flush_count  = flush_count_r;
`else
   assign hz.stall_cycles = {CNT_W{1'b0}};
   assign hz.flush_count  = {CNT_W{1'b0}};
`endif
endmodule
